// File: rtl/blend_pkg.sv
// Shared constants and types for the blend pipeline: factor/equation codes,
// component positions inside a pixel and the pipeline depth.
package blend_pkg;

  // Blend factor codes; any unlisted code (15) resolves to zero
  localparam logic [3:0] FACTOR_ZERO                     = 4'd0;
  localparam logic [3:0] FACTOR_ONE                      = 4'd1;
  localparam logic [3:0] FACTOR_DST_COLOR                = 4'd2;
  localparam logic [3:0] FACTOR_SRC_COLOR                = 4'd3;
  localparam logic [3:0] FACTOR_ONE_MINUS_DST_COLOR      = 4'd4;
  localparam logic [3:0] FACTOR_ONE_MINUS_SRC_COLOR      = 4'd5;
  localparam logic [3:0] FACTOR_SRC_ALPHA                = 4'd6;
  localparam logic [3:0] FACTOR_ONE_MINUS_SRC_ALPHA      = 4'd7;
  localparam logic [3:0] FACTOR_DST_ALPHA                = 4'd8;
  localparam logic [3:0] FACTOR_ONE_MINUS_DST_ALPHA      = 4'd9;
  localparam logic [3:0] FACTOR_SRC_ALPHA_SATURATE       = 4'd10;
  localparam logic [3:0] FACTOR_CONSTANT_COLOR           = 4'd11;
  localparam logic [3:0] FACTOR_ONE_MINUS_CONSTANT_COLOR = 4'd12;
  localparam logic [3:0] FACTOR_CONSTANT_ALPHA           = 4'd13;
  localparam logic [3:0] FACTOR_ONE_MINUS_CONSTANT_ALPHA = 4'd14;

  // Combine equations; codes 5-7 behave as ADD
  localparam logic [2:0] EQ_ADD              = 3'd0;
  localparam logic [2:0] EQ_SUBTRACT         = 3'd1;
  localparam logic [2:0] EQ_REVERSE_SUBTRACT = 3'd2;
  localparam logic [2:0] EQ_MIN              = 3'd3;
  localparam logic [2:0] EQ_MAX              = 3'd4;

  // Component index inside a pixel (index 0 = LSBs); R in the MSBs, A last
  localparam int unsigned COLOR_R_POS = 3;
  localparam int unsigned COLOR_G_POS = 2;
  localparam int unsigned COLOR_B_POS = 1;
  localparam int unsigned COLOR_A_POS = 0;

  localparam int unsigned PIPE_DEPTH = 3;

  // Per-beat configuration captured at acceptance
  typedef struct packed {
    logic       enable;
    logic [3:0] sfactor_rgb;
    logic [3:0] dfactor_rgb;
    logic [3:0] sfactor_a;
    logic [3:0] dfactor_a;
    logic [2:0] equation_rgb;
    logic [2:0] equation_a;
  } blend_conf_t;

endpackage

// File: rtl/blend_pipeline_if.sv
// Stream bundle for the blend pipeline: input beat (source, destination, tag)
// and output beat (blended colour, tag), each with a valid/ready handshake.
//   master : producer/consumer side (drives s_*, m_ready)
//   slave  : pipeline side (drives s_ready, m_valid, m_color, m_tag)
interface blend_pipeline_if #(
  parameter int unsigned PIXEL_WIDTH = 32,
  parameter int unsigned TAG_WIDTH   = 16
);
  logic                   s_valid;
  logic                   s_ready;
  logic [PIXEL_WIDTH-1:0] s_source;
  logic [PIXEL_WIDTH-1:0] s_dest;
  logic [TAG_WIDTH-1:0]   s_tag;
  logic                   m_valid;
  logic                   m_ready;
  logic [PIXEL_WIDTH-1:0] m_color;
  logic [TAG_WIDTH-1:0]   m_tag;

  modport master (
    output s_valid, s_source, s_dest, s_tag, m_ready,
    input  s_ready, m_valid, m_color, m_tag
  );

  modport slave (
    input  s_valid, s_source, s_dest, s_tag, m_ready,
    output s_ready, m_valid, m_color, m_tag
  );
endinterface

// File: rtl/blend_channel.sv
// One colour component of the blend: multiply+normalise (stage 2), then
// combine+saturate (stage 3). Factors arrive already resolved.
//   clk_i/rst_ni : clock, synchronous active-low reset
//   adv_i        : pipeline advance enable
//   en_i, eq_i   : blend enable and equation of the beat in stage 1
//   src_i/dst_i  : raw components; sf_i/df_i : resolved factors
//   color_o      : registered result component
module blend_channel
  import blend_pkg::*;
#(
  parameter int unsigned SUB_PIXEL_WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       adv_i,
  input  logic                       en_i,
  input  logic [2:0]                 eq_i,
  input  logic [SUB_PIXEL_WIDTH-1:0] src_i,
  input  logic [SUB_PIXEL_WIDTH-1:0] dst_i,
  input  logic [SUB_PIXEL_WIDTH-1:0] sf_i,
  input  logic [SUB_PIXEL_WIDTH-1:0] df_i,
  output logic [SUB_PIXEL_WIDTH-1:0] color_o
);
  localparam int unsigned W  = SUB_PIXEL_WIDTH;
  localparam int unsigned WS = W + 1;
  localparam int unsigned WP = 2 * W + 1;

  logic [W-1:0] sp_q, dp_q, src_q, dst_q, color_q, color_d;
  logic         en_q;
  logic [2:0]   eq_q;
  logic [W:0]   sum_c, sub_c, rsub_c;

  // a*f/ONE rounded so that 0 and ONE*ONE are exact
  function automatic logic [W-1:0] norm_mul(input logic [W-1:0] a, input logic [W-1:0] f);
    logic [WP-1:0] p;
    logic [WP-1:0] s;
    p = WP'(a) * WP'(f);
    s = p + (p >> W) + WP'(1);
    return W'(s >> W);
  endfunction

  // Stage 2: weighted source/destination terms
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sp_q  <= '0;
      dp_q  <= '0;
      src_q <= '0;
      dst_q <= '0;
      en_q  <= 1'b0;
      eq_q  <= '0;
    end else if (adv_i) begin
      sp_q  <= norm_mul(src_i, sf_i);
      dp_q  <= norm_mul(dst_i, df_i);
      src_q <= src_i;
      dst_q <= dst_i;
      en_q  <= en_i;
      eq_q  <= eq_i;
    end
  end

  // Stage 3 combine in W+1 bits; bit W flags overflow (add) or borrow (sub)
  always_comb begin
    sum_c   = WS'(sp_q) + WS'(dp_q);
    sub_c   = WS'(sp_q) - WS'(dp_q);
    rsub_c  = WS'(dp_q) - WS'(sp_q);
    color_d = '0;
    case (eq_q)
      EQ_SUBTRACT:         color_d = sub_c[W] ? '0 : sub_c[W-1:0];
      EQ_REVERSE_SUBTRACT: color_d = rsub_c[W] ? '0 : rsub_c[W-1:0];
      EQ_MIN:              color_d = (src_q < dst_q) ? src_q : dst_q;
      EQ_MAX:              color_d = (src_q > dst_q) ? src_q : dst_q;
      default:             color_d = sum_c[W] ? '1 : sum_c[W-1:0];
    endcase
    if (!en_q) color_d = src_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      color_q <= '0;
    end else if (adv_i) begin
      color_q <= color_d;
    end
  end

  assign color_o = color_q;

endmodule

// File: rtl/blend_pipeline.sv
// Three-stage framebuffer blend: stage 1 resolves factors, per-component
// channels multiply/normalise and combine/saturate. Config travels with beats.
//   aclk, resetn : clock, synchronous active-low reset
//   conf*        : blend enable, factors, equations, constant colour
//   bus (slave)  : s_* input beat handshake, m_* output beat handshake
module blend_pipeline
  import blend_pkg::*;
#(
  parameter int unsigned SUB_PIXEL_WIDTH     = 8,
  parameter int unsigned NUMBER_OF_SUB_PIXEL = 4,
  parameter int unsigned TAG_WIDTH           = 16
) (
  input  logic                                           aclk,
  input  logic                                           resetn,
  input  logic                                           confEnable,
  input  logic [3:0]                                     confSFactorRgb,
  input  logic [3:0]                                     confDFactorRgb,
  input  logic [3:0]                                     confSFactorA,
  input  logic [3:0]                                     confDFactorA,
  input  logic [2:0]                                     confEquationRgb,
  input  logic [2:0]                                     confEquationA,
  input  logic [SUB_PIXEL_WIDTH*NUMBER_OF_SUB_PIXEL-1:0] confConstColor,
  blend_pipeline_if.slave                                bus
);
  localparam int unsigned W           = SUB_PIXEL_WIDTH;
  localparam int unsigned N           = NUMBER_OF_SUB_PIXEL;
  localparam int unsigned PIXEL_WIDTH = W * N;
  localparam logic [W-1:0] ONE        = '1;

  blend_conf_t            conf_c;
  logic                   adv;
  logic [PIPE_DEPTH-1:0]  valid_q;
  logic [PIXEL_WIDTH-1:0] src_q, dst_q, sf_q, df_q, sf_d, df_d, color;
  logic                   en_q;
  logic [2:0]             eq_rgb_q, eq_a_q;
  logic [TAG_WIDTH-1:0]   tag_q [PIPE_DEPTH];
  logic [W-1:0]           src_a, dst_a, const_a;

  assign conf_c = '{enable: confEnable,
                    sfactor_rgb: confSFactorRgb, dfactor_rgb: confDFactorRgb,
                    sfactor_a: confSFactorA, dfactor_a: confDFactorA,
                    equation_rgb: confEquationRgb, equation_a: confEquationA};

  // Whole pipeline moves when the output slot is empty or being drained
  assign adv         = !bus.m_valid || bus.m_ready;
  assign bus.s_ready = adv || !resetn;

  assign src_a   = bus.s_source[COLOR_A_POS*W +: W];
  assign dst_a   = bus.s_dest[COLOR_A_POS*W +: W];
  assign const_a = confConstColor[COLOR_A_POS*W +: W];

  function automatic logic [W-1:0] sel_factor(
    input logic [3:0] code, input logic is_alpha,
    input logic [W-1:0] sc, input logic [W-1:0] dc, input logic [W-1:0] cc,
    input logic [W-1:0] sa, input logic [W-1:0] da, input logic [W-1:0] ca);
    logic [W-1:0] f, sat;
    sat = (sa < (ONE - da)) ? sa : (ONE - da);
    case (code)
      FACTOR_ZERO:                     f = '0;
      FACTOR_ONE:                      f = ONE;
      FACTOR_DST_COLOR:                f = dc;
      FACTOR_SRC_COLOR:                f = sc;
      FACTOR_ONE_MINUS_DST_COLOR:      f = ONE - dc;
      FACTOR_ONE_MINUS_SRC_COLOR:      f = ONE - sc;
      FACTOR_SRC_ALPHA:                f = sa;
      FACTOR_ONE_MINUS_SRC_ALPHA:      f = ONE - sa;
      FACTOR_DST_ALPHA:                f = da;
      FACTOR_ONE_MINUS_DST_ALPHA:      f = ONE - da;
      FACTOR_SRC_ALPHA_SATURATE:       f = is_alpha ? ONE : sat;
      FACTOR_CONSTANT_COLOR:           f = cc;
      FACTOR_ONE_MINUS_CONSTANT_COLOR: f = ONE - cc;
      FACTOR_CONSTANT_ALPHA:           f = ca;
      FACTOR_ONE_MINUS_CONSTANT_ALPHA: f = ONE - ca;
      default:                         f = '0;
    endcase
    return f;
  endfunction

  // Stage 1 factor resolution; the alpha component uses the alpha codes
  always_comb begin
    sf_d = '0;
    df_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sf_d[i*W +: W] = sel_factor((i == COLOR_A_POS) ? conf_c.sfactor_a : conf_c.sfactor_rgb,
                                  i == COLOR_A_POS, bus.s_source[i*W +: W],
                                  bus.s_dest[i*W +: W], confConstColor[i*W +: W],
                                  src_a, dst_a, const_a);
      df_d[i*W +: W] = sel_factor((i == COLOR_A_POS) ? conf_c.dfactor_a : conf_c.dfactor_rgb,
                                  i == COLOR_A_POS, bus.s_source[i*W +: W],
                                  bus.s_dest[i*W +: W], confConstColor[i*W +: W],
                                  src_a, dst_a, const_a);
    end
  end

  // Stage 1 registers plus valid/tag shift chains for all stages
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      valid_q  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      sf_q     <= '0;
      df_q     <= '0;
      en_q     <= 1'b0;
      eq_rgb_q <= '0;
      eq_a_q   <= '0;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) tag_q[i] <= '0;
    end else if (adv) begin
      valid_q  <= {valid_q[PIPE_DEPTH-2:0], bus.s_valid};
      src_q    <= bus.s_source;
      dst_q    <= bus.s_dest;
      sf_q     <= sf_d;
      df_q     <= df_d;
      en_q     <= conf_c.enable;
      eq_rgb_q <= conf_c.equation_rgb;
      eq_a_q   <= conf_c.equation_a;
      tag_q[0] <= bus.s_tag;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_chan
    blend_channel #(.SUB_PIXEL_WIDTH(W)) u_chan (
      .clk_i   (aclk),
      .rst_ni  (resetn),
      .adv_i   (adv),
      .en_i    (en_q),
      .eq_i    ((g == COLOR_A_POS) ? eq_a_q : eq_rgb_q),
      .src_i   (src_q[g*W +: W]),
      .dst_i   (dst_q[g*W +: W]),
      .sf_i    (sf_q[g*W +: W]),
      .df_i    (df_q[g*W +: W]),
      .color_o (color[g*W +: W])
    );
  end

  assign bus.m_valid = valid_q[PIPE_DEPTH-1];
  assign bus.m_color = color;
  assign bus.m_tag   = tag_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_blend_pipeline.sv
// Directed bench for blend_pipeline: hand-computed blend vectors, a stalled
// stream, per-beat config capture, bypass and mid-flight reset.
module tb_blend_pipeline;
  import blend_pkg::*;

  localparam int unsigned SPW = 8;
  localparam int unsigned NSP = 4;
  localparam int unsigned TW  = 16;
  localparam int unsigned PW  = SPW * NSP;

  typedef struct {
    logic [PW-1:0] color;
    logic [TW-1:0] tag;
    int unsigned   acc;
    bit            lat;
  } exp_t;

  logic          aclk = 1'b0;
  logic          resetn;
  logic          conf_en;
  logic [3:0]    sf_rgb, df_rgb, sf_a, df_a;
  logic [2:0]    eq_rgb, eq_a;
  logic [PW-1:0] const_color;

  exp_t        expq[$];
  int unsigned edge_n  = 0;
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  blend_pipeline_if #(.PIXEL_WIDTH(PW), .TAG_WIDTH(TW)) bus ();

  blend_pipeline #(
    .SUB_PIXEL_WIDTH(SPW), .NUMBER_OF_SUB_PIXEL(NSP), .TAG_WIDTH(TW)
  ) dut (
    .aclk            (aclk),
    .resetn          (resetn),
    .confEnable      (conf_en),
    .confSFactorRgb  (sf_rgb),
    .confDFactorRgb  (df_rgb),
    .confSFactorA    (sf_a),
    .confDFactorA    (df_a),
    .confEquationRgb (eq_rgb),
    .confEquationA   (eq_a),
    .confConstColor  (const_color),
    .bus             (bus)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic set_conf(input logic en, input logic [3:0] sfr, input logic [3:0] dfr,
                          input logic [3:0] sfa, input logic [3:0] dfa,
                          input logic [2:0] eqr, input logic [2:0] eqa);
    conf_en = en; sf_rgb = sfr; df_rgb = dfr; sf_a = sfa; df_a = dfa;
    eq_rgb = eqr; eq_a = eqa;
  endtask

  // One clock: drive inputs, score what transfers on the coming edge, step
  task automatic cycle(input logic sv, input logic [PW-1:0] src, input logic [PW-1:0] dst,
                       input logic [PW-1:0] exp_color, input logic [TW-1:0] tag,
                       input logic mr, input bit lat, output bit acc_o, output bit xfer_o);
    exp_t e;
    acc_o  = 1'b0;
    xfer_o = 1'b0;
    bus.s_valid = sv; bus.s_source = src; bus.s_dest = dst; bus.s_tag = tag;
    bus.m_ready = mr;
    #1;
    if (!resetn) begin
      check("rst_s_ready", 32'(bus.s_ready), 32'd1);
    end else begin
      if (bus.m_valid) begin
        if (expq.size() == 0) begin
          check("spurious_valid", 32'(bus.m_valid), 32'd0);
        end else begin
          check("m_color", bus.m_color, expq[0].color);
          check("m_tag", 32'(bus.m_tag), 32'(expq[0].tag));
          if (bus.m_ready) begin
            if (expq[0].lat) check("latency", edge_n - expq[0].acc, 32'd3);
            void'(expq.pop_front());
            xfer_o = 1'b1;
          end
        end
      end
      if (sv && bus.s_ready) begin
        e.color = exp_color; e.tag = tag; e.acc = edge_n; e.lat = lat;
        expq.push_back(e);
        acc_o = 1'b1;
      end
    end
    @(posedge aclk);
    edge_n++;
    #1;
  endtask

  task automatic drain();
    bit a, x;
    for (int k = 0; k < 20 && expq.size() != 0; k++)
      cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, a, x);
    check("drain", expq.size(), 32'd0);
  endtask

  task automatic one(input logic [PW-1:0] src, input logic [PW-1:0] dst,
                     input logic [PW-1:0] exp_color, input logic [TW-1:0] tag);
    bit a, x;
    cycle(1'b1, src, dst, exp_color, tag, 1'b1, 1'b1, a, x);
    check("accept", 32'(a), 32'd1);
    drain();
  endtask

  function automatic logic [PW-1:0] keep_alpha(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = '0;
    r[COLOR_A_POS*SPW +: SPW] = p[COLOR_A_POS*SPW +: SPW];
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit            a, x;
    int unsigned   acc, nout;
    logic [PW-1:0] src;

    resetn = 1'b0;
    const_color = '0;
    set_conf(1'b1, FACTOR_ONE, FACTOR_ZERO, FACTOR_ONE, FACTOR_ZERO, EQ_ADD, EQ_ADD);
    bus.s_valid = 1'b0; bus.s_source = '0; bus.s_dest = '0; bus.s_tag = '0;
    bus.m_ready = 1'b1;
    @(posedge aclk);
    #1;

    // Reset: beats offered during reset must never be accepted
    cycle(1'b1, 32'hAAAAAAAA, 32'h0, 32'hAAAAAAAA, 16'hDEAD, 1'b1, 1'b0, a, x);
    cycle(1'b1, 32'h55555555, 32'h0, 32'h55555555, 16'hBEEF, 1'b1, 1'b0, a, x);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_color", bus.m_color, 32'd0);
    check("rst_m_tag", 32'(bus.m_tag), 32'd0);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("idle_no_valid", 32'(bus.m_valid), 32'd0);
      cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, a, x);
    end

    // Source-over with alpha ONE/ONE
    set_conf(1'b1, FACTOR_SRC_ALPHA, FACTOR_ONE_MINUS_SRC_ALPHA, FACTOR_ONE, FACTOR_ONE,
             EQ_ADD, EQ_ADD);
    one(32'hFF000080, 32'h0000FFFF, 32'h80007FFF, 16'h1001);

    set_conf(1'b1, FACTOR_ONE, FACTOR_ONE, FACTOR_ONE, FACTOR_ONE, EQ_ADD, EQ_ADD);
    one(32'hC0C0C0C0, 32'h80808080, 32'hFFFFFFFF, 16'h1002);
    set_conf(1'b1, FACTOR_ONE, FACTOR_ONE, FACTOR_ONE, FACTOR_ONE, EQ_SUBTRACT, EQ_SUBTRACT);
    one(32'h40404040, 32'h80808080, 32'h00000000, 16'h1003);
    set_conf(1'b1, FACTOR_ONE, FACTOR_ONE, FACTOR_ONE, FACTOR_ONE,
             EQ_REVERSE_SUBTRACT, EQ_REVERSE_SUBTRACT);
    one(32'h10203040, 32'h80808080, 32'h70605040, 16'h1004);

    // MIN/MAX ignore factors (ZERO factors here)
    set_conf(1'b1, FACTOR_ZERO, FACTOR_ZERO, FACTOR_ZERO, FACTOR_ZERO, EQ_MIN, EQ_MIN);
    one(32'h10F02080, 32'h20103040, 32'h10102040, 16'h1005);
    set_conf(1'b1, FACTOR_ZERO, FACTOR_ZERO, FACTOR_ZERO, FACTOR_ZERO, EQ_MAX, EQ_MAX);
    one(32'h10F02080, 32'h20103040, 32'h20F03080, 16'h1006);

    // Code 15 acts as ZERO, equation 7 acts as ADD
    set_conf(1'b1, 4'd15, FACTOR_ONE, 4'd15, FACTOR_ONE, 3'd7, 3'd7);
    one(32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0, 16'h1007);

    // Constant colour / constant alpha factors
    const_color = 32'hFF00FF80;
    set_conf(1'b1, FACTOR_CONSTANT_COLOR, FACTOR_ONE_MINUS_CONSTANT_COLOR,
             FACTOR_CONSTANT_ALPHA, FACTOR_ONE_MINUS_CONSTANT_ALPHA, EQ_ADD, EQ_ADD);
    one(32'h40506070, 32'h11223344, 32'h40226059, 16'h1008);

    // Alpha saturate and destination factors
    set_conf(1'b1, FACTOR_SRC_ALPHA_SATURATE, FACTOR_DST_COLOR,
             FACTOR_SRC_ALPHA_SATURATE, FACTOR_DST_ALPHA, EQ_ADD, EQ_ADD);
    one(32'hFF80FF40, 32'h204060C0, 32'h432F63D0, 16'h1009);

    // One-minus variants
    set_conf(1'b1, FACTOR_ONE_MINUS_DST_COLOR, FACTOR_SRC_COLOR,
             FACTOR_ONE_MINUS_DST_ALPHA, FACTOR_ONE_MINUS_SRC_COLOR, EQ_ADD, EQ_ADD);
    one(32'h80FF0010, 32'hFF8000F0, 32'h80FF00E0, 16'h100A);

    // Stream of 8 with m_ready pattern 1,0,0,1
    set_conf(1'b1, FACTOR_ONE, FACTOR_ONE, FACTOR_ONE, FACTOR_ONE, EQ_ADD, EQ_ADD);
    acc = 0;
    nout = 0;
    for (int k = 0; k < 200 && (acc < 8 || expq.size() != 0); k++) begin
      src = '0;
      src[COLOR_R_POS*SPW +: SPW] = SPW'(acc * 16);
      src[COLOR_G_POS*SPW +: SPW] = SPW'(acc * 16 + 1);
      src[COLOR_B_POS*SPW +: SPW] = SPW'(acc * 16 + 2);
      src[COLOR_A_POS*SPW +: SPW] = SPW'(acc * 16 + 3);
      cycle(acc < 8, src, 32'h01010101, src + 32'h01010101, TW'(16'h2000 + acc),
            (k % 4 == 0) || (k % 4 == 3), 1'b0, a, x);
      if (a) acc++;
      if (x) nout++;
    end
    check("stream_in", acc, 32'd8);
    check("stream_out", nout, 32'd8);

    // Config sampled per beat: ONE for beats 1-2, ZERO for 3-4, then bypass
    for (int i = 0; i < 4; i++) begin
      src = 32'hA1B2C3D4 + 32'(i * 32'h01010101);
      if (i < 2) begin
        set_conf(1'b1, FACTOR_ONE, FACTOR_ZERO, FACTOR_ONE, FACTOR_ZERO, EQ_ADD, EQ_ADD);
        cycle(1'b1, src, 32'h0F0F0F0F, src, TW'(16'h3000 + i), 1'b1, 1'b0, a, x);
      end else begin
        set_conf(1'b1, FACTOR_ZERO, FACTOR_ZERO, FACTOR_ONE, FACTOR_ZERO, EQ_ADD, EQ_ADD);
        cycle(1'b1, src, 32'h0F0F0F0F, keep_alpha(src), TW'(16'h3000 + i), 1'b1, 1'b0, a, x);
      end
      check("conf_accept", 32'(a), 32'd1);
    end
    set_conf(1'b0, FACTOR_ZERO, FACTOR_ZERO, FACTOR_ZERO, FACTOR_ZERO, EQ_SUBTRACT, EQ_SUBTRACT);
    cycle(1'b1, 32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF, 16'h3004, 1'b1, 1'b1, a, x);
    set_conf(1'b1, FACTOR_ONE, FACTOR_ONE, FACTOR_ONE, FACTOR_ONE, EQ_ADD, EQ_ADD);
    drain();

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      src = 32'h01010101 * 32'(i + 1);
      cycle(1'b1, src, 32'h10101010, src + 32'h10101010, TW'(16'h4000 + i), 1'b1, 1'b0, a, x);
    end
    check("full_m_valid", 32'(bus.m_valid), 32'd1);
    resetn = 1'b0;
    cycle(1'b1, 32'h77777777, 32'h0, 32'h77777777, 16'h4FFF, 1'b0, 1'b0, a, x);
    expq.delete();
    resetn = 1'b1;
    check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("mid_rst_m_color", bus.m_color, 32'd0);
    check("mid_rst_m_tag", 32'(bus.m_tag), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("no_stale", 32'(bus.m_valid), 32'd0);
      cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, a, x);
    end
    one(32'h20202020, 32'h30303030, 32'h50505050, 16'h5000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/blend_pipeline.md
BLEND_PIPELINE -- requirements
Module: blend_pipeline

Interface
REQ-001 Parameter SUB_PIXEL_WIDTH, default 8: bits per colour component.
REQ-002 Parameter NUMBER_OF_SUB_PIXEL, default 4: components per pixel; the last component is alpha, the rest are colour. Order is R,G,B,A, with R in the MSBs.
REQ-003 Parameter TAG_WIDTH, default 16: width of the sideband passed through unchanged.
REQ-004 Derived PIXEL_WIDTH = SUB_PIXEL_WIDTH*NUMBER_OF_SUB_PIXEL.
REQ-005 Ports, one clock; reset is synchronous and active-low:
  aclk  in  1  clock, all logic on rising edge
  resetn  in  1  synchronous reset, active low
  confEnable  in  1  0 = bypass source colour
  confSFactorRgb/confDFactorRgb  in  4 each  colour-component factors
  confSFactorA/confDFactorA  in  4 each  alpha factors
  confEquationRgb/confEquationA  in  3 each  combine equation
  confConstColor  in  PIXEL_WIDTH  constant blend colour
  s_valid  in  1 / s_ready  out  1  input handshake
  s_source, s_dest  in  PIXEL_WIDTH  source and destination pixel
  s_tag  in  TAG_WIDTH  sideband
  m_valid  out  1 / m_ready  in  1  output handshake
  m_color  out  PIXEL_WIDTH  blended pixel
  m_tag  out  TAG_WIDTH  sideband

Function
REQ-006 Handshake: a beat transfers when valid&&ready on the same edge. m_valid SHALL NOT depend combinationally on m_ready.
REQ-007 Pipeline: 3 register stages.
  - Stage 1 resolves the factors.
  - Stage 2 multiplies and normalises.
  - Stage 3 combines and saturates.
REQ-008 Latency: with m_ready held high, a beat accepted on edge N SHALL appear on m_valid/m_color at edge N+3. Throughput is 1 beat per clock.
REQ-009 Advance enable: adv = !m_valid || m_ready; s_ready = adv. All stages hold while adv=0. No beat is lost or duplicated. Bubbles propagate as valid=0.
REQ-010 Config sampling: all conf* inputs SHALL be sampled at beat acceptance and carried with that beat. A config change affects only beats accepted afterwards.
REQ-011 Factor codes:
  - 0 ZERO, 1 ONE, 2 DST_COLOR, 3 SRC_COLOR
  - 4 ONE_MINUS_DST_COLOR, 5 ONE_MINUS_SRC_COLOR
  - 6 SRC_ALPHA, 7 ONE_MINUS_SRC_ALPHA, 8 DST_ALPHA, 9 ONE_MINUS_DST_ALPHA
  - 10 SRC_ALPHA_SATURATE
  - 11 CONSTANT_COLOR, 12 ONE_MINUS_CONSTANT_COLOR, 13 CONSTANT_ALPHA, 14 ONE_MINUS_CONSTANT_ALPHA
  - Any code is legal in either S or D; code 15 SHALL act as ZERO.
REQ-012 ONE = all ones, i.e. 2^W-1. ONE_MINUS_x = (2^W-1)-x.
REQ-013 SRC_ALPHA_SATURATE: colour components use min(as, ONE-ad); the alpha component uses ONE.
REQ-014 Product normalisation: p = a*f (2W bits); result = (p + (p>>W) + 1) >> W. This is exact for 0 and ONE*ONE=ONE.
REQ-015 Equation codes:
  - 0 ADD: min(S+D, ONE)
  - 1 SUBTRACT: max(S-D, 0)
  - 2 REVERSE_SUBTRACT: max(D-S, 0)
  - 3 MIN: min(src, dst), factors ignored
  - 4 MAX: max(src, dst), factors ignored
  - Codes 5-7 SHALL act as ADD.
REQ-016 Intermediate sums SHALL be W+1 bits wide and SHALL never wrap.
REQ-017 confEnable=0 on a beat: m_color = s_source of that beat, with identical latency and handshake.
REQ-018 m_tag SHALL leave aligned with its own beat.

Reset
REQ-019 While resetn=0 at an edge: all stage valids = 0, m_valid = 0, m_color = 0, m_tag = 0.
REQ-020 s_ready SHALL be 1 during reset, but no beat SHALL be accepted while resetn=0.
REQ-021 Beats in flight when reset is asserted SHALL be discarded. The first beat accepted after release SHALL appear 3 clocks later.

Structure
REQ-022 A shared package blend_pkg SHALL hold:
  - factor and equation code constants
  - COLOR_R/G/B/A_POS
  - the pipeline depth constant (3)
REQ-023 A sub-module blend_channel SHALL handle one component: multiply, normalise, equation, and saturate stages. It SHALL be instantiated NUMBER_OF_SUB_PIXEL times, the last instance with the alpha config. Factor selection stays in the top level.

Verification
REQ-024 RGB ADD, SRC_ALPHA/ONE_MINUS_SRC_ALPHA, src=FF000080, dst=0000FFFF -> m_color=80007FFF at edge N+3.
REQ-025 ADD, ONE/ONE, src=C0C0C0C0, dst=80808080 -> FFFFFFFF (saturated); SUBTRACT, same factors, src=40404040, dst=80808080 -> 00000000.
REQ-026 MIN, src=10F02080, dst=20103040 -> 10102040; MAX with the same inputs -> 20F03080.
REQ-027 Stream 8 beats with m_ready toggling 1,0,0,1,... -> all 8 results arrive in order, none dropped or duplicated, with m_color/m_tag stable while m_valid && !m_ready.
REQ-028 Change confSFactorRgb from ONE to ZERO between beat 2 and beat 3 -> beats 1-2 use ONE, beats 3+ use ZERO; confEnable=0 beat -> m_color = s_source.
REQ-029 Assert resetn=0 for 1 clock with 3 beats in flight -> m_valid=0 the next cycle, no stale beat is emitted, and a new beat emerges 3 clocks after acceptance.
